// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
//   Shared definitions for the branch resolve unit:
//     - RV32I conditional-branch funct3 encodings
//     - 2-bit bimodal counter encodings (SNT/WNT/WT/ST)
//     - bht_next(): saturating counter update used by the BHT
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

  // Conditional branch funct3 encodings. 010 and 011 are unused in RV32I.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bimodal 2-bit saturating counter states. The MSB is the prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not-taken
    WNT = 2'b01,  // weakly not-taken (reset value)
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } bht_cnt_e;

  // Saturating update of one BHT counter with the resolved outcome.
  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_branch_compare.sv
// -----------------------------------------------------------------------------
// branch_compare
//   Purely combinational branch condition evaluator for the six RV32I
//   conditional branches, including the unsigned forms.
//
//   Ports:
//     rs1, rs2  in   XLEN  forwarded operands
//     funct3    in   3     branch type
//     taken     out  1     condition holds (0 when funct3 is not a branch)
//     legal     out  1     funct3 encodes one of the six branches
// -----------------------------------------------------------------------------
module branch_compare
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            legal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = ~lt_u;
      default: legal = 1'b0;  // 010 / 011: not a conditional branch
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves RV32I conditional branches in EX, maintains a bimodal BHT of
//   2-bit saturating counters for IF prediction, raises a registered flush
//   with a redirect PC on mispredict, and counts branches and mispredicts.
//
//   Ports:
//     clk               in   1      rising-edge clock
//     reset             in   1      asynchronous, active-high reset
//     if_pc             in   XLEN   fetch PC for the BHT lookup
//     if_pred_taken     out  1      MSB of BHT[index(if_pc)] (pre-update)
//     ex_valid          in   1      EX holds a valid instruction
//     ex_branch         in   1      EX instruction is a conditional branch
//     ex_funct3         in   3      branch type
//     ex_rs1, ex_rs2    in   XLEN   forwarded operands
//     ex_pc             in   XLEN   PC of the EX instruction
//     ex_imm            in   XLEN   sign-extended B-immediate
//     ex_pred_taken     in   1      prediction made for this instruction
//     ex_taken          out  1      actual outcome (0 unless resolving)
//     flush             out  1      registered, one cycle after a mispredict
//     redirect_pc       out  XLEN   registered, correct next PC while flush=1
//     illegal_branch    out  1      registered, ex_branch with funct3 010/011
//     branch_count      out  CNT_W  resolved legal branches (wraps)
//     mispredict_count  out  CNT_W  mispredicted branches (wraps)
//
//   Qualification: there is no backpressure. An EX instruction is consumed in
//   the cycle where ex_valid=1; it is acted on only when ex_branch=1 and flush
//   is low, since flush=1 marks the EX slot as wrong-path.
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic             ex_taken,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // BHT kept in flops so the reset initialisation to WNT is real.
  logic [1:0] bht [BHT_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cmp_taken;
  logic             cmp_legal;
  logic             ex_live;      // valid branch slot not squashed by flush
  logic             res;          // legal branch resolving this cycle
  logic             mispredict;
  logic             illegal_now;
  logic [XLEN-1:0]  target_pc;
  logic             unused_if_pc_bits;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Only the index bits of the fetch PC matter for the lookup.
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // Read reflects the stored value only; an EX update to the same entry
  // becomes visible the following cycle.
  assign if_pred_taken = bht[if_idx][1];

  branch_compare #(
    .XLEN (XLEN)
  ) u_branch_compare (
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .funct3 (ex_funct3),
    .taken  (cmp_taken),
    .legal  (cmp_legal)
  );

  assign ex_live     = ex_valid & ex_branch & ~flush;
  assign res         = ex_live & cmp_legal;
  assign illegal_now = ex_live & ~cmp_legal;
  assign ex_taken    = res & cmp_taken;
  assign mispredict  = res & (cmp_taken != ex_pred_taken);

  // Correct fall-through or target; both wrap modulo 2^XLEN.
  assign target_pc = cmp_taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));

  // Flush / redirect / illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush          <= 1'b0;
      redirect_pc    <= '0;
      illegal_branch <= 1'b0;
    end else begin
      flush          <= mispredict;
      illegal_branch <= illegal_now;
      if (mispredict) redirect_pc <= target_pc;
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (res)        branch_count     <= branch_count + CNT_W'(1);
      if (mispredict) mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

  // Branch history table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= WNT;
    end else if (res) begin
      bht[ex_idx] <= bht_next(bht[ex_idx], cmp_taken);
    end
  end

endmodule
